// File: rtl/basic_gate_checker.sv
// Stimulus/response checker for the two-input basic gates block: walks all four
// input vectors, samples the seven gate outputs and accumulates mismatch results.
module basic_gate_checker #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       y,
    output logic             a1,
    output logic             a2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [6:0]       fail_mask
);

    localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int unsigned CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF - 1);
    localparam int unsigned SUM_W      = ERR_W + 3;
    localparam logic [SUM_W-1:0] ERR_MAX = {3'b000, {ERR_W{1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    state_t           state;
    logic [1:0]       vec;
    logic [CNT_W-1:0] cnt;

    logic [6:0]       expected;
    logic [6:0]       mism;
    logic [2:0]       mism_cnt;
    logic [SUM_W-1:0] err_sum;
    logic [ERR_W-1:0] err_next;

    // Bit i corresponds to gate output y(i+1); a = a1, b = a2.
    function automatic logic [6:0] gate_model(input logic a, input logic b);
        gate_model = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    always_comb begin
        expected = gate_model(vec[1], vec[0]);
        mism     = y ^ expected;
        mism_cnt = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            mism_cnt = mism_cnt + 3'(mism[i]);
        end
        err_sum  = {3'b000, err_count} + SUM_W'(mism_cnt);
        err_next = (err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec       <= '0;
            cnt       <= '0;
            a1        <= 1'b0;
            a2        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count <= '0;
                        fail_mask <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        vec       <= '0;
                        a1        <= 1'b0;
                        a2        <= 1'b0;
                        busy      <= 1'b1;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    cnt   <= CNT_LOAD;
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CHECK: begin
                    err_count <= err_next;
                    fail_mask <= fail_mask | mism;
                    if (vec == 2'd3) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= DONE;
                    end else begin
                        // Stimulus advances on the same edge that leaves CHECK.
                        vec       <= vec + 2'd1;
                        {a1, a2}  <= vec + 2'd1;
                        state     <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_basic_gate_checker.sv
// Scoreboard bench for basic_gate_checker: behavioural gate models with injectable
// faults drive y, expected run results are queued at start and popped at done.
module tb_basic_gate_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start0, start1, start2;
    logic [6:0] y0, y1, y2;
    logic a1_0, a2_0, busy0, done0, pass0;
    logic a1_1, a2_1, busy1, done1, pass1;
    logic a1_2, a2_2, busy2, done2, pass2;
    logic [7:0] err0;
    logic [3:0] err1;
    logic [7:0] err2;
    logic [6:0] mask0, mask1, mask2;

    int mode0, mode1, mode2;
    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int         done_edge;
        logic [7:0] err;
        logic [6:0] mask;
        logic       pss;
    } exp_t;
    exp_t sb[$];

    logic [1:0] obs_ab [64];
    logic       obs_busy [64];
    logic       obs_done0;
    logic [7:0] obs_err0;
    logic [6:0] obs_mask0;

    function automatic logic [6:0] ref_gates(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    // mode 1: y6 stuck at 0; mode 2: every output inverted.
    function automatic logic [6:0] apply_mode(input logic [6:0] g, input int m);
        logic [6:0] r;
        r = g;
        if (m == 1) r[5] = 1'b0;
        else if (m == 2) r = ~g;
        return r;
    endfunction

    assign y0 = apply_mode(ref_gates(a1_0, a2_0), mode0);
    assign y1 = apply_mode(ref_gates(a1_1, a2_1), mode1);
    assign y2 = apply_mode(ref_gates(a1_2, a2_2), mode2);

    basic_gate_checker #(.SETTLE_CYCLES(4), .ERR_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .y(y0), .a1(a1_0), .a2(a2_0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_mask(mask0));
    basic_gate_checker #(.SETTLE_CYCLES(4), .ERR_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y(y1), .a1(a1_1), .a2(a2_1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_mask(mask1));
    basic_gate_checker #(.SETTLE_CYCLES(1), .ERR_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .y(y2), .a1(a1_2), .a2(a2_2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_mask(mask2));

    int sel;
    logic s_a1, s_a2, s_busy, s_done, s_pass;
    logic [7:0] s_err;
    logic [6:0] s_mask;

    always_comb begin
        s_a1 = a1_0; s_a2 = a2_0; s_busy = busy0; s_done = done0;
        s_pass = pass0; s_err = err0; s_mask = mask0;
        if (sel == 1) begin
            s_a1 = a1_1; s_a2 = a2_1; s_busy = busy1; s_done = done1;
            s_pass = pass1; s_err = {4'b0000, err1}; s_mask = mask1;
        end else if (sel == 2) begin
            s_a1 = a1_2; s_a2 = a2_2; s_busy = busy2; s_done = done2;
            s_pass = pass2; s_err = err2; s_mask = mask2;
        end
    end

    task automatic set_start(input int which, input logic v);
        if (which == 0) start0 = v;
        else if (which == 1) start1 = v;
        else start2 = v;
    endtask

    // Pulses start, then records per-edge observations until done or timeout (-1).
    task automatic run_dut(input int which, input bit extra, output int done_edge);
        int n;
        sel = which;
        @(negedge clk);
        set_start(which, 1'b1);
        @(posedge clk);
        #1;
        set_start(which, 1'b0);
        n = 0;
        obs_ab[0] = {s_a1, s_a2};
        obs_busy[0] = s_busy;
        obs_done0 = s_done;
        obs_err0 = s_err;
        obs_mask0 = s_mask;
        while (!s_done && n < 200) begin
            if (extra && (n + 1 == 3 || n + 1 == 10)) set_start(which, 1'b1);
            @(posedge clk);
            #1;
            n++;
            set_start(which, 1'b0);
            if (n < 64) begin
                obs_ab[n] = {s_a1, s_a2};
                obs_busy[n] = s_busy;
            end
        end
        done_edge = s_done ? n : -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({a1_0, a2_0, busy0, done0, pass0, err0, mask0} !== '0) begin
            tests_failed++;
            $display("FAIL reset_dut0: got %b expected all zero",
                     {a1_0, a2_0, busy0, done0, pass0, err0, mask0});
        end
        tests_run++;
        if ({busy1, done1, err1, busy2, done2, err2} !== '0) begin
            tests_failed++;
            $display("FAIL reset_dut1_2: got %b expected all zero",
                     {busy1, done1, err1, busy2, done2, err2});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_result(input string name, input int which, input int edge_seen);
        exp_t e;
        sel = which;
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
            return;
        end
        e = sb.pop_front();
        if (edge_seen !== e.done_edge || s_err !== e.err || s_mask !== e.mask || s_pass !== e.pss) begin
            tests_failed++;
            $display("FAIL %s: got edge=%0d err=%0d mask=%h pass=%b expected edge=%0d err=%0d mask=%h pass=%b",
                     name, edge_seen, s_err, s_mask, s_pass, e.done_edge, e.err, e.mask, e.pss);
        end
    endtask

    task automatic test_correct;
        int de, bad_ab, bad_busy;
        logic [1:0] ev;
        mode0 = 0;
        sb.push_back('{24, 8'd0, 7'h00, 1'b1});
        run_dut(0, 1'b0, de);
        check_result("correct_run", 0, de);
        bad_ab = 0; bad_busy = 0;
        for (int k = 0; k <= 24; k++) begin
            ev = (k < 24) ? 2'(k / 6) : 2'd3;
            if (obs_ab[k] !== ev) bad_ab++;
            if (obs_busy[k] !== (k < 24)) bad_busy++;
        end
        tests_run++;
        if (bad_ab != 0) begin
            tests_failed++;
            $display("FAIL vector_sequence: got %0d wrong edges expected 0", bad_ab);
        end
        tests_run++;
        if (bad_busy != 0) begin
            tests_failed++;
            $display("FAIL busy_window: got %0d wrong edges expected 0", bad_busy);
        end
    endtask

    task automatic test_stuck_y6;
        int de;
        mode0 = 1;
        sb.push_back('{24, 8'd2, 7'h20, 1'b0});
        run_dut(0, 1'b0, de);
        check_result("stuck_y6", 0, de);
    endtask

    task automatic test_inverted;
        int de;
        mode0 = 2;
        sb.push_back('{24, 8'd28, 7'h7F, 1'b0});
        run_dut(0, 1'b0, de);
        check_result("inverted", 0, de);
        mode1 = 2;
        sb.push_back('{24, 8'd15, 7'h7F, 1'b0});
        run_dut(1, 1'b0, de);
        check_result("inverted_saturate", 1, de);
    endtask

    task automatic test_back_to_back;
        int de;
        mode0 = 1;
        sb.push_back('{24, 8'd2, 7'h20, 1'b0});
        run_dut(0, 1'b1, de);
        check_result("ignored_starts", 0, de);
    endtask

    task automatic test_reset_midrun;
        int de;
        mode0 = 2;
        sel = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        tests_run++;
        if ({a1_0, a2_0, busy0} !== 3'b101 || err0 !== 8'd14) begin
            tests_failed++;
            $display("FAIL pre_reset_state: got a=%b%b busy=%b err=%0d expected a=10 busy=1 err=14",
                     a1_0, a2_0, busy0, err0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({a1_0, a2_0, busy0, done0, pass0, err0, mask0} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset_midrun: got %b expected all zero",
                     {a1_0, a2_0, busy0, done0, pass0, err0, mask0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        mode0 = 0;
        sb.push_back('{24, 8'd0, 7'h00, 1'b1});
        run_dut(0, 1'b0, de);
        check_result("post_reset_run", 0, de);
    endtask

    task automatic test_settle1;
        int de;
        mode2 = 2;
        sb.push_back('{12, 8'd28, 7'h7F, 1'b0});
        run_dut(2, 1'b0, de);
        check_result("settle1_inverted", 2, de);
        mode2 = 0;
        sb.push_back('{12, 8'd0, 7'h00, 1'b1});
        run_dut(2, 1'b0, de);
        tests_run++;
        if (obs_done0 !== 1'b0 || obs_err0 !== 8'd0 || obs_mask0 !== 7'h00) begin
            tests_failed++;
            $display("FAIL restart_clear: got done=%b err=%0d mask=%h expected done=0 err=0 mask=00",
                     obs_done0, obs_err0, obs_mask0);
        end
        check_result("settle1_correct", 2, de);
        sb.push_back('{12, 8'd0, 7'h00, 1'b1});
        run_dut(2, 1'b0, de);
        check_result("settle1_repeat", 2, de);
    endtask

    initial begin
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        mode0 = 0; mode1 = 0; mode2 = 0;
        sel = 0;
        test_reset;
        test_correct;
        test_stuck_y6;
        test_inverted;
        test_back_to_back;
        test_reset_midrun;
        test_settle1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/basic_gate_checker.md
Name: basic_gate_checker

Overview:
- Hardware stimulus/response partner for the two-input basic gates block.
- Drives the a1/a2 inputs of the gates block through all four input vectors, waits a settle interval for each, then samples the seven gate outputs and compares them against the expected truth table.
- Reports a pass/fail flag, a mismatch count and a per-gate sticky failure mask, so gate correctness can be checked without a simulator monitor.

Parameters:
SETTLE_CYCLES, 4, cycles each vector is held before its outputs are sampled (values below 1 behave as 1)
ERR_W, 8, width of the mismatch counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a run; ignored while busy=1
y  input  7  gate outputs under test; y[0]=y1 ... y[6]=y7
a1  output  1  stimulus to gate input a1 (registered)
a2  output  1  stimulus to gate input a2 (registered)
busy  output  1  run in progress
done  output  1  run complete; held until next accepted start
pass  output  1  valid when done=1; 1 iff err_count==0
err_count  output  ERR_W  total bit mismatches in the last run, saturating
fail_mask  output  7  sticky per-gate mismatch flags, bit i = y[i]

Behaviour:
- Reset (async, rst_n=0): a1=0, a2=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, state IDLE, vec=0, settle counter=0. Reset mid-run aborts immediately with no partial results retained.
- Expected gate map, per vector (A=a1, B=a2):
  - y1=A&B, y2=A|B, y3=~A, y4=~(A&B)
  - y5=~(A|B), y6=A^B, y7=~(A^B)
- Vector order, vec 0..3: (a1,a2) = 00, 01, 10, 11.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
  - IDLE/DONE + start=1: clear err_count, fail_mask, done and pass; vec=0; a1/a2 = vec bits; busy=1; go to DRIVE.
  - DRIVE (1 cycle): a1/a2 already stable; load settle counter; go to SETTLE.
  - SETTLE (SETTLE_CYCLES cycles): a1/a2 held constant; then go to CHECK.
  - CHECK (1 cycle): mism = y XOR expected(vec).
    - err_count += popcount(mism), saturating at 2^ERR_W-1.
    - fail_mask |= mism.
    - If vec==3: go to DONE. Otherwise vec+1, update a1/a2 on the same edge, go to DRIVE.
  - Entering DONE: busy=0, done=1, pass=(final err_count==0). Outputs hold; a1/a2 keep the last vector (11).
- Latency: with the start-sampling edge as edge 0, done rises at edge 4*(SETTLE_CYCLES+2) (24 for default).
- start while busy=1 is ignored with no effect. start in DONE restarts; done drops on that edge.
- y is sampled only in CHECK. Glitches in DRIVE/SETTLE have no effect.
- Saturation: err_count never wraps. pass still reflects err_count==0.
- a1/a2 change only on edges leaving IDLE/DONE (on start) or leaving CHECK.

Test Plan:
- Correct combinational gate model on y, start pulse -> a1/a2 step 00,01,10,11, each held 6 cycles; done=1 at edge 24; pass=1, err_count=0, fail_mask=0x00.
- y6 stuck at 0, otherwise correct -> mismatches at vectors 01 and 10; err_count=2, fail_mask=0x20, pass=0.
- All y bits inverted relative to the correct model -> err_count=28, fail_mask=0x7F, pass=0. Repeat with ERR_W=4 -> err_count=15 (saturated), pass=0.
- start pulsed again at edges 3 and 10 during a run -> ignored; done still at edge 24; results identical to a single-start run.
- rst_n low during SETTLE of vec 2 -> all outputs return to reset values asynchronously. A new start afterwards gives a clean correct run: pass=1, err_count=0.
- SETTLE_CYCLES=1 with a correct model -> done at edge 12, pass=1. Second start from DONE -> done drops on that edge, results cleared, run repeats identically.
